// File: rtl/clk_tick_gen_if.sv
// Bundles the register-side controls (div/frac/load) and the consumer strobes of clk_tick_gen.
interface clk_tick_gen_if #(
  parameter int WIDTH  = 16,
  parameter int FRAC_W = 4
);
  logic              en_i;
  logic              sync_i;
  logic [WIDTH-1:0]  div_i;
  logic [FRAC_W-1:0] frac_i;
  logic              load_i;
  logic              load_ack_o;
  logic              tick_o;
  logic              mid_o;

  modport master (
    output en_i, sync_i, div_i, frac_i, load_i,
    input  load_ack_o, tick_o, mid_o
  );

  modport slave (
    input  en_i, sync_i, div_i, frac_i, load_i,
    output load_ack_o, tick_o, mid_o
  );
endinterface

// File: rtl/clk_tick_gen.sv
// Programmable tick/mid strobe generator with shadowed divisor reload and sync restart.
// Define CLK_TICK_FRAC_EN to enable the fractional accumulator that stretches periods by one cycle.
module clk_tick_gen #(
  parameter int               WIDTH       = 16,
  parameter int               FRAC_W      = 4,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(868)
) (
  input logic           clk_i,
  input logic           resetn_i,
  clk_tick_gen_if.slave bus
);

  // One extra counter bit so a maximal divisor plus the stretch cycle still fits.
  localparam int CW = WIDTH + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_divAct;
  logic [WIDTH-1:0] r_divShadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_mid;
  logic             r_ack;

  logic             w_ext;
  logic [CW-1:0]    w_term;
  logic             w_atTerm;
  logic [CW-1:0]    w_cntNext;
  logic             w_midHit;
  logic             w_apply;

`ifdef CLK_TICK_FRAC_EN
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W-1:0] r_fracAct;
  logic [FRAC_W-1:0] r_fracShadow;
  logic              r_ext;
  logic [FRAC_W:0]   w_accSum;

  assign w_ext    = r_ext;
  assign w_accSum = {1'b0, r_acc} + {1'b0, r_fracAct};
`else
  logic w_unused_frac;

  assign w_ext         = 1'b0;
  assign w_unused_frac = ^bus.frac_i;
`endif

  assign w_term    = {1'b0, r_divAct} + CW'(w_ext);
  assign w_atTerm  = (r_cnt == w_term);
  assign w_cntNext = w_atTerm ? '0 : r_cnt + CW'(1);
  assign w_midHit  = (w_cntNext == {1'b0, (r_divAct >> 1)});

  // A pending divisor only swaps in at a period boundary, a sync restart, or while frozen.
  assign w_apply = r_pending & (bus.sync_i | ~bus.en_i | w_atTerm);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_cnt        <= '0;
      r_divAct     <= DEFAULT_DIV;
      r_divShadow  <= DEFAULT_DIV;
      r_pending    <= 1'b0;
      r_tick       <= 1'b0;
      r_mid        <= 1'b0;
      r_ack        <= 1'b0;
`ifdef CLK_TICK_FRAC_EN
      r_acc        <= '0;
      r_fracAct    <= '0;
      r_fracShadow <= '0;
      r_ext        <= 1'b0;
`endif
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_divAct  <= r_divShadow;
`ifdef CLK_TICK_FRAC_EN
        r_fracAct <= r_fracShadow;
`endif
      end

      // A load landing on the apply edge re-arms pending for the newer value.
      if (bus.load_i) begin
        r_divShadow  <= bus.div_i;
`ifdef CLK_TICK_FRAC_EN
        r_fracShadow <= bus.frac_i;
`endif
        r_pending    <= 1'b1;
      end else if (w_apply) begin
        r_pending    <= 1'b0;
      end

      if (bus.sync_i) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_mid  <= 1'b0;
`ifdef CLK_TICK_FRAC_EN
        r_acc  <= '0;
        r_ext  <= 1'b0;
`endif
      end else if (bus.en_i) begin
        r_cnt  <= w_cntNext;
        r_tick <= w_atTerm;
        r_mid  <= w_midHit;
`ifdef CLK_TICK_FRAC_EN
        if (w_atTerm) begin
          r_acc <= w_accSum[FRAC_W-1:0];
          r_ext <= w_accSum[FRAC_W];
        end
`endif
      end else begin
        r_tick <= 1'b0;
        r_mid  <= 1'b0;
      end
    end
  end

  assign bus.tick_o     = r_tick;
  assign bus.mid_o      = r_mid;
  assign bus.load_ack_o = r_ack;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: expected tick/mid/ack cycles are queued when stimulus
// is driven and matched cycle by cycle against the strobes.
`timescale 1ns/1ps
module tb_clk_tick_gen;

  localparam int WIDTH     = 16;
  localparam int FRAC_W    = 4;
  localparam int KIND_TICK = 0;
  localparam int KIND_MID  = 1;
  localparam int KIND_ACK  = 2;

  typedef struct {
    int cycle;
    int kind;
  } expect_t;

  typedef struct {
    logic [WIDTH-1:0] div;
    int               periods;
    int               expPeriod;
    int               expMidOff;
  } vector_t;

  logic clk_i    = 1'b0;
  logic resetn_i = 1'b0;

  clk_tick_gen_if #(.WIDTH(WIDTH), .FRAC_W(FRAC_W)) bus ();

  clk_tick_gen #(
    .WIDTH      (WIDTH),
    .FRAC_W     (FRAC_W),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int      cycle     = 0;
  int      checks    = 0;
  int      errors    = 0;
  bit      monitorOn = 1'b0;
  expect_t expQ[$];

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got {ack,mid,tick}=%b expected %b", name, cycle, actual, expected);
    end
  endtask

  // Each negedge, gather the events due this cycle and compare all three strobes at once.
  always @(negedge clk_i) begin
    logic [2:0] expBits;
    expBits = 3'b000;
    if (monitorOn) begin
      for (int i = expQ.size() - 1; i >= 0; i--) begin
        if (expQ[i].cycle == cycle) begin
          expBits[expQ[i].kind] = 1'b1;
          expQ.delete(i);
        end
      end
      checkOutput("strobes", {bus.load_ack_o, bus.mid_o, bus.tick_o}, expBits);
    end
  end

  task automatic stepClk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cycle < target) stepClk();
  endtask

  task automatic pushEvent(input int c, input int kind);
    expQ.push_back('{c, kind});
  endtask

  // Ticks land every period after start; mids sit midOff into each period, up to the last tick.
  task automatic pushPeriods(input int start, input int period, input int midOff, input int count);
    int lastTick;
    lastTick = start + period * count;
    for (int n = 1; n <= count; n++) pushEvent(start + period * n, KIND_TICK);
    for (int n = 0; n <= count; n++) begin
      if ((midOff + period * n > 0) && (start + midOff + period * n <= lastTick))
        pushEvent(start + midOff + period * n, KIND_MID);
    end
  endtask

  // Load a divisor then sync, so the new value is acked on the sync edge and counting restarts.
  task automatic restart(input logic [WIDTH-1:0] div, input logic [FRAC_W-1:0] frac, output int s);
    monitorOn  = 1'b0;
    expQ.delete();
    bus.en_i   = 1'b1;
    bus.div_i  = div;
    bus.frac_i = frac;
    bus.load_i = 1'b1;
    stepClk();
    bus.load_i = 1'b0;
    bus.sync_i = 1'b1;
    s = cycle + 1;
    pushEvent(s, KIND_ACK);
    stepClk();
    bus.sync_i = 1'b0;
    monitorOn  = 1'b1;
  endtask

  task automatic loadDiv(input int edgeCycle, input logic [WIDTH-1:0] div);
    waitUntil(edgeCycle - 1);
    bus.div_i  = div;
    bus.load_i = 1'b1;
    stepClk();
    bus.load_i = 1'b0;
  endtask

  task automatic endWindow(input int last);
    waitUntil(last);
    @(negedge clk_i);
    #1;
    monitorOn = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missed events: %0d never seen, first due at cycle %0d", expQ.size(), expQ[0].cycle);
    end
    expQ.delete();
  endtask

  task automatic applyStimulus(input vector_t v);
    int s;
    restart(v.div, '0, s);
    pushPeriods(s, v.expPeriod, v.expMidOff, v.periods);
    endWindow(s + v.expPeriod * v.periods);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t vectors[7];
    int      s;
    int      t;
    bit      longP;

    vectors[0] = '{16'd3, 4, 4,  1};
    vectors[1] = '{16'd0, 4, 1,  0};
    vectors[2] = '{16'd1, 4, 2,  0};
    vectors[3] = '{16'd2, 3, 3,  1};
    vectors[4] = '{16'd9, 2, 10, 4};
    vectors[5] = '{16'd6, 2, 7,  3};
    vectors[6] = '{16'd5, 2, 6,  2};

    bus.en_i   = 1'b0;
    bus.sync_i = 1'b0;
    bus.div_i  = '0;
    bus.frac_i = '0;
    bus.load_i = 1'b0;

    repeat (3) stepClk();
    checkOutput("reset", {bus.load_ack_o, bus.mid_o, bus.tick_o}, 3'b000);

    $display("[TB] default divisor after reset");
    bus.en_i  = 1'b1;
    resetn_i  = 1'b1;
    s         = cycle;
    monitorOn = 1'b1;
    pushPeriods(s, 869, 434, 2);
    endWindow(s + 1738);

    $display("[TB] divisor table");
    for (int i = 0; i < 7; i++) applyStimulus(vectors[i]);

    $display("[TB] load mid-period");
    restart(16'd9, '0, s);
    pushEvent(s + 4,  KIND_MID);
    pushEvent(s + 10, KIND_TICK);
    pushEvent(s + 10, KIND_ACK);
    pushPeriods(s + 10, 4, 1, 3);
    loadDiv(s + 4, 16'd3);
    endWindow(s + 22);

    $display("[TB] enable gap");
    restart(16'd3, '0, s);
    pushEvent(s + 1,  KIND_MID);
    pushEvent(s + 4,  KIND_TICK);
    pushEvent(s + 5,  KIND_MID);
    pushEvent(s + 13, KIND_TICK);
    pushEvent(s + 14, KIND_MID);
    pushEvent(s + 17, KIND_TICK);
    waitUntil(s + 5);
    bus.en_i = 1'b0;
    waitUntil(s + 10);
    bus.en_i = 1'b1;
    endWindow(s + 17);

    $display("[TB] sync with pending load");
    restart(16'd9, '0, s);
    pushEvent(s + 4,  KIND_MID);
    pushEvent(s + 7,  KIND_ACK);
    pushEvent(s + 9,  KIND_MID);
    pushEvent(s + 13, KIND_TICK);
    pushEvent(s + 15, KIND_MID);
    pushEvent(s + 19, KIND_TICK);
    loadDiv(s + 3, 16'd5);
    waitUntil(s + 6);
    bus.sync_i = 1'b1;
    stepClk();
    bus.sync_i = 1'b0;
    endWindow(s + 19);

    $display("[TB] two loads in one period");
    restart(16'd9, '0, s);
    pushEvent(s + 4,  KIND_MID);
    pushEvent(s + 10, KIND_TICK);
    pushEvent(s + 10, KIND_ACK);
    pushPeriods(s + 10, 8, 3, 2);
    loadDiv(s + 2, 16'd5);
    loadDiv(s + 5, 16'd7);
    endWindow(s + 26);

    $display("[TB] load on the apply edge");
    restart(16'd3, '0, s);
    pushEvent(s + 1,  KIND_MID);
    pushEvent(s + 4,  KIND_TICK);
    pushEvent(s + 4,  KIND_ACK);
    pushEvent(s + 6,  KIND_MID);
    pushEvent(s + 10, KIND_TICK);
    pushEvent(s + 10, KIND_ACK);
    pushEvent(s + 13, KIND_MID);
    pushEvent(s + 18, KIND_TICK);
    loadDiv(s + 2, 16'd5);
    loadDiv(s + 4, 16'd7);
    endWindow(s + 18);

    $display("[TB] fractional stretch");
    restart(16'd3, 4'd4, s);
    pushEvent(s + 1, KIND_MID);
    t = s;
    for (int p = 1; p <= 17; p++) begin
`ifdef CLK_TICK_FRAC_EN
      longP = (p > 1) && ((p - 1) % 4 == 0);
`else
      longP = 1'b0;
`endif
      t = t + (longP ? 5 : 4);
      pushEvent(t, KIND_TICK);
      if (p < 17) pushEvent(t + 1, KIND_MID);
    end
    endWindow(t);

    $display("[TB] asynchronous reset mid-period");
    restart(16'd3, '0, s);
    monitorOn  = 1'b0;
    expQ.delete();
    bus.div_i  = 16'd5;
    bus.load_i = 1'b1;
    stepClk();
    bus.load_i = 1'b0;
    checkOutput("pre-reset", {bus.load_ack_o, bus.mid_o, bus.tick_o}, 3'b010);
    resetn_i = 1'b0;
    #1;
    checkOutput("async reset", {bus.load_ack_o, bus.mid_o, bus.tick_o}, 3'b000);
    repeat (2) stepClk();
    resetn_i  = 1'b1;
    s         = cycle;
    monitorOn = 1'b1;
    pushPeriods(s, 869, 434, 1);
    endWindow(s + 869);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
